// File: rtl/synreg_pipe.sv
// synreg_pipe: DEPTH-stage handshaked register pipeline with
// clock enable, synchronous clear and occupancy count.
module synreg_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             sclr_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CNTW-1:0]  r_cnt;

  // w_rdy[i] is ready of stage i; w_rdy[DEPTH] stands for downstream
  logic [DEPTH:0]   w_rdy;
  // w_give[i] loads stage i; w_give[i+1] means stage i hands its word on
  logic [DEPTH:0]   w_give;
  logic [WIDTH-1:0] w_din [DEPTH];
  logic             w_in_fire;
  logic             w_out_fire;

  assign in_ready   = clk_en & sclr_n & w_rdy[0] & ~rst;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready & clk_en & sclr_n;
  assign out_data   = r_data[DEPTH-1];
  assign out_valid  = r_v[DEPTH-1];
  assign count      = r_cnt;
  assign full       = (r_cnt == CNTW'(DEPTH));
  assign empty      = (r_cnt == '0);

  // Ready chain: a stage is ready if it or any stage beyond is free,
  // or the downstream consumer takes the last word
  always_comb begin
    logic w_acc;
    w_acc        = out_ready;
    w_rdy[DEPTH] = w_acc;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_v[i];
      w_rdy[i] = w_acc;
    end
  end

  // Transfer events between neighbouring stages
  always_comb begin
    w_give[0] = w_in_fire;
    for (int i = 0; i < DEPTH; i++) begin
      w_give[i+1] = r_v[i] & w_rdy[i+1];
    end
  end

  // Source word for each stage: input for stage 0, predecessor otherwise
  always_comb begin
    w_din[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_din[i] = r_data[i-1];
    end
  end

  // Stage registers, valid flags and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_v   <= '0;
      r_cnt <= '0;
    end else if (clk_en) begin
      if (!sclr_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_data[i] <= '0;
        end
        r_v   <= '0;
        r_cnt <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_give[i]) begin
            r_data[i] <= w_din[i];
            r_v[i]    <= 1'b1;
          end else if (w_give[i+1]) begin
            r_v[i]    <= 1'b0;
          end
        end
        case ({w_in_fire, w_out_fire})
          2'b10:   r_cnt <= r_cnt + CNTW'(1);
          2'b01:   r_cnt <= r_cnt - CNTW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule
